// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encodings and stage indices.
package hazard_ctrl_pkg;

    typedef logic [0:0] hazard_state_e;

    localparam hazard_state_e RUN = 1'b0;
    localparam hazard_state_e LU  = 1'b1;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Single saturating event counter used by the hazard controller's optional perf block.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble/flush controller. Optional event counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE   = 5,
    parameter int NSRC     = 2,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cache_miss,
    input  logic                  d_cache_miss,
    input  logic [REG_W-1:0]      id_ex_rd,
    input  logic                  id_ex_read_mem,
    input  logic [NSRC*REG_W-1:0] if_id_rs,
    input  logic [NSRC-1:0]       if_id_rs_used,
    input  logic                  flush_req,
    output logic [NSTAGE-1:0]     stall,
    output logic [NSTAGE-1:0]     bubble,
    output logic [NSTAGE-1:0]     flush,
    output logic [PERF_W-1:0]     perf_dmiss,
    output logic [PERF_W-1:0]     perf_imiss,
    output logic [PERF_W-1:0]     perf_lu,
    output logic [PERF_W-1:0]     perf_flush
);

    localparam int LCW = $clog2(LOAD_LAT + 1);

    hazard_state_e    state_r;
    logic [LCW-1:0]   lu_cnt_r;
    logic [REG_W-1:0] lu_rd_r;
    logic             flush_pend_r;

    logic             miss_s;
    logic             eff_flush_s;
    logic [REG_W-1:0] ref_rd_s;
    logic             match_s;
    logic             lu_hit_s;
    logic             lu_active_s;

    // While bubbling, compare against the latched load destination; new hits are not acted on in LU.
    always_comb begin
        ref_rd_s = (state_r == LU) ? lu_rd_r : id_ex_rd;
        match_s  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (if_id_rs_used[k] && (if_id_rs[k*REG_W +: REG_W] == ref_rd_s)) begin
                match_s = 1'b1;
            end else begin
                match_s = match_s;
            end
        end
        lu_hit_s    = id_ex_read_mem && (id_ex_rd != '0) && match_s;
        miss_s      = d_cache_miss || i_cache_miss;
        eff_flush_s = !miss_s && (flush_req || flush_pend_r);
        lu_active_s = !miss_s && !eff_flush_s && ((state_r == LU) || lu_hit_s);
    end

    // Stage controls follow the fixed priority: miss, then flush, then load-use.
    always_comb begin
        stall  = '0;
        bubble = '0;
        flush  = '0;
        if (rst) begin
            stall = '0;
        end else if (miss_s) begin
            stall = '1;
        end else if (eff_flush_s) begin
            flush[STG_IFID] = 1'b1;
            flush[STG_IDEX] = 1'b1;
        end else if (lu_active_s) begin
            stall[STG_PC]    = 1'b1;
            stall[STG_IFID]  = 1'b1;
            bubble[STG_IDEX] = 1'b1;
        end else begin
            stall = '0;
        end
    end

    // Load-use sequencing and flush deferral; everything freezes while a miss is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RUN;
            lu_cnt_r     <= '0;
            lu_rd_r      <= '0;
            flush_pend_r <= 1'b0;
        end else if (miss_s) begin
            flush_pend_r <= flush_pend_r || flush_req;
        end else if (eff_flush_s) begin
            state_r      <= RUN;
            lu_cnt_r     <= '0;
            flush_pend_r <= 1'b0;
        end else if (state_r == RUN) begin
            if (lu_hit_s && (LOAD_LAT > 1)) begin
                state_r  <= LU;
                lu_cnt_r <= LCW'(LOAD_LAT - 1);
                lu_rd_r  <= id_ex_rd;
            end else begin
                state_r <= RUN;
            end
        end else begin
            if (lu_cnt_r <= LCW'(1)) begin
                state_r  <= RUN;
                lu_cnt_r <= '0;
            end else begin
                lu_cnt_r <= lu_cnt_r - LCW'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_dmiss (
        .clk(clk), .rst(rst), .inc(d_cache_miss), .count(perf_dmiss)
    );
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_imiss (
        .clk(clk), .rst(rst), .inc(i_cache_miss && !d_cache_miss), .count(perf_imiss)
    );
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_lu (
        .clk(clk), .rst(rst), .inc(lu_active_s), .count(perf_lu)
    );
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_flush (
        .clk(clk), .rst(rst), .inc(eff_flush_s), .count(perf_flush)
    );
`else
    assign perf_dmiss = '0;
    assign perf_imiss = '0;
    assign perf_lu    = '0;
    assign perf_flush = '0;
`endif

endmodule
